// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and types for the pipeline stage register
package pipe_stage_reg_pkg;

  localparam int CB_MEMREAD  = 2;
  localparam int CB_MEMWRITE = 4;
  localparam int CB_REGWRITE = 6;
  localparam int CB_WORD     = 8;
  localparam int STALL_W     = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // Payload bus: ctrl, result, store data, rd, branch target, branch taken.
  function automatic int payloadWidth(input int ctrlW, input int dataW,
                                      input int addrW, input int pcW);
    return ctrlW + 2 * dataW + addrW + pcW + 1;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - payload register with load enable and synchronous clear
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with flush, optional skid entry and stall counter
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int SKID   = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [DATA_W-1:0]   in_store_data,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic [PC_W-1:0]     in_pc_branch,
  input  logic                in_pc_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_store_data,
  output logic [ADDR_W-1:0]   out_rd,
  output logic [PC_W-1:0]     out_pc_branch,
  output logic                out_pc_src,
  output logic [STALL_W-1:0]  stall_cycles
);

  localparam int PAY_W = payloadWidth(CTRL_W, DATA_W, ADDR_W, PC_W);

  stage_state_t       state;
  logic               readyReg;
  logic               headValid, accept, deq;
  logic               headLoad, headClear, skidLoad, skidClear;
  logic [PAY_W-1:0]   inBus, headD, headQ, skidQ;
  logic [STALL_W-1:0] stallCnt;

  assign inBus = {in_ctrl, in_result, in_store_data, in_rd, in_pc_branch, in_pc_src};
  assign {out_ctrl, out_result, out_store_data, out_rd, out_pc_branch, out_pc_src} = headQ;

  assign headValid    = (state != EMPTY);
  assign out_valid    = headValid;
  assign stall_cycles = stallCnt;

  // Without a skid entry the stage can refill only while the head drains.
  assign in_ready = (SKID != 0) ? (resetn && readyReg)
                                : (resetn && (!headValid || out_ready));
  assign accept = in_valid && in_ready && !flush;
  assign deq    = headValid && out_ready;

  always_comb begin
    headLoad  = 1'b0;
    headClear = 1'b0;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    headD     = inBus;
    case (state)
      EMPTY: headLoad = accept;
      ONE: begin
        if (accept && deq)  headLoad  = 1'b1;
        else if (accept)    skidLoad  = 1'b1;
        else if (deq)       headClear = 1'b1;
      end
      TWO: begin
        if (deq) begin
          headLoad  = 1'b1;
          headD     = skidQ;
          skidClear = 1'b1;
        end
      end
      default: ;
    endcase
    if (flush) begin
      headLoad  = 1'b0;
      skidLoad  = 1'b0;
      headClear = 1'b1;
      skidClear = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      state    <= EMPTY;
      readyReg <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !deq) begin
            state    <= TWO;
            readyReg <= 1'b0;
          end else if (!accept && deq) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            state    <= ONE;
            readyReg <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(.W(PAY_W)) uHead (
    .clock (clock),
    .resetn(resetn),
    .clear (headClear),
    .load  (headLoad),
    .d     (headD),
    .q     (headQ)
  );

  if (SKID != 0) begin : gSkid
    pipe_entry_reg #(.W(PAY_W)) uSkid (
      .clock (clock),
      .resetn(resetn),
      .clear (skidClear),
      .load  (skidLoad),
      .d     (inBus),
      .q     (skidQ)
    );
  end else begin : gNoSkid
    assign skidQ = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stallCnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stallCnt != {STALL_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg in skid and single-register modes
module tb_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        rstS, rstF, rdyS, rdyF, flush;
  logic        inValid, inPcSrc;
  logic [8:0]  inCtrl;
  logic [31:0] inResult, inStoreData, inPcBranch;
  logic [4:0]  inRd;

  logic        sInReady, sOutValid, sPcSrc;
  logic [8:0]  sCtrl;
  logic [31:0] sResult, sStore, sBranch;
  logic [4:0]  sRd;
  logic [15:0] sStall;

  logic        fInReady, fOutValid, fPcSrc;
  logic [8:0]  fCtrl;
  logic [31:0] fResult, fStore, fBranch;
  logic [4:0]  fRd;
  logic [15:0] fStall;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.SKID(1)) uSkid (
    .clock(clock), .resetn(rstS), .flush(flush),
    .in_valid(inValid), .in_ready(sInReady),
    .in_ctrl(inCtrl), .in_result(inResult), .in_store_data(inStoreData),
    .in_rd(inRd), .in_pc_branch(inPcBranch), .in_pc_src(inPcSrc),
    .out_valid(sOutValid), .out_ready(rdyS),
    .out_ctrl(sCtrl), .out_result(sResult), .out_store_data(sStore),
    .out_rd(sRd), .out_pc_branch(sBranch), .out_pc_src(sPcSrc),
    .stall_cycles(sStall)
  );

  pipe_stage_reg #(.SKID(0)) uFlat (
    .clock(clock), .resetn(rstF), .flush(flush),
    .in_valid(inValid), .in_ready(fInReady),
    .in_ctrl(inCtrl), .in_result(inResult), .in_store_data(inStoreData),
    .in_rd(inRd), .in_pc_branch(inPcBranch), .in_pc_src(inPcSrc),
    .out_valid(fOutValid), .out_ready(rdyF),
    .out_ctrl(fCtrl), .out_result(fResult), .out_store_data(fStore),
    .out_rd(fRd), .out_pc_branch(fBranch), .out_pc_src(fPcSrc),
    .stall_cycles(fStall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [31:0] r,
                       input logic pcSrc = 1'b0, input logic [31:0] br = 32'h0);
    inValid     = v;
    inResult    = r;
    inStoreData = r + 32'd100;
    inRd        = r[4:0];
    inCtrl      = 9'h144;
    inPcSrc     = pcSrc;
    inPcBranch  = br;
  endtask

  initial begin
    rstS = 1'b0; rstF = 1'b0; rdyS = 1'b0; rdyF = 1'b0; flush = 1'b0;
    setIn(1'b1, 32'd5);

    // reset held two cycles with input offered
    tick(); tick();
    chk("rst_out_valid", {31'd0, sOutValid}, 32'd0);
    chk("rst_result", sResult, 32'd0);
    chk("rst_ctrl", {23'd0, sCtrl}, 32'd0);
    chk("rst_in_ready", {31'd0, sInReady}, 32'd0);
    chk("rst_stall", {16'd0, sStall}, 32'd0);
    rstS = 1'b1;
    setIn(1'b0, 32'd0);
    #1;
    chk("rel_in_ready", {31'd0, sInReady}, 32'd1);

    // streaming ten entries
    rdyS = 1'b1;
    for (int i = 0; i < 10; i++) begin
      setIn(1'b1, i);
      tick();
      chk("stream_valid", {31'd0, sOutValid}, 32'd1);
      chk("stream_result", sResult, i);
      if (i == 3) begin
        chk("stream_store", sStore, 32'd103);
        chk("stream_rd", {27'd0, sRd}, 32'd3);
        chk("stream_ctrl", {23'd0, sCtrl}, 32'h144);
      end
    end
    setIn(1'b0, 32'd0);
    tick();
    chk("stream_drain_valid", {31'd0, sOutValid}, 32'd0);
    chk("stream_drain_result", sResult, 32'd0);

    // back-pressure: A, then B with out_ready low, C held upstream
    setIn(1'b1, 32'hA);
    tick();
    setIn(1'b1, 32'hB);
    rdyS = 1'b0;
    #1;
    chk("bp_ready_onB", {31'd0, sInReady}, 32'd1);
    tick();
    chk("bp_head_A", sResult, 32'hA);
    chk("bp_ready_two", {31'd0, sInReady}, 32'd0);
    chk("bp_stall1", {16'd0, sStall}, 32'd1);
    setIn(1'b1, 32'hC);
    tick();
    tick();
    chk("bp_stall3", {16'd0, sStall}, 32'd3);
    chk("bp_hold_A", sResult, 32'hA);
    rdyS = 1'b1;
    tick();
    chk("bp_head_B", sResult, 32'hB);
    chk("bp_ready_back", {31'd0, sInReady}, 32'd1);
    chk("bp_stall_hold", {16'd0, sStall}, 32'd3);
    tick();
    chk("bp_head_C", sResult, 32'hC);
    setIn(1'b0, 32'd0);
    tick();
    chk("bp_empty", {31'd0, sOutValid}, 32'd0);

    // flush while full, with D offered
    rdyS = 1'b0;
    setIn(1'b1, 32'h11);
    tick();
    setIn(1'b1, 32'h22);
    tick();
    chk("fl_two_ready", {31'd0, sInReady}, 32'd0);
    chk("fl_stall4", {16'd0, sStall}, 32'd4);
    setIn(1'b1, 32'h33, 1'b1, 32'h80);
    flush = 1'b1;
    tick();
    chk("fl_valid", {31'd0, sOutValid}, 32'd0);
    chk("fl_result", sResult, 32'd0);
    chk("fl_pc_src", {31'd0, sPcSrc}, 32'd0);
    chk("fl_in_ready", {31'd0, sInReady}, 32'd1);
    chk("fl_stall", {16'd0, sStall}, 32'd4);
    flush = 1'b0;
    rdyS = 1'b1;
    setIn(1'b0, 32'd0);
    tick();
    chk("fl_D_dropped", {31'd0, sOutValid}, 32'd0);

    // branch redirect
    setIn(1'b1, 32'h7, 1'b1, 32'h40);
    tick();
    chk("br_pc_src", {31'd0, sPcSrc}, 32'd1);
    chk("br_target", sBranch, 32'h40);
    setIn(1'b0, 32'd0);
    tick();
    chk("br_pc_src_gone", {31'd0, sPcSrc}, 32'd0);
    chk("br_target_gone", sBranch, 32'd0);

    // stall counter saturation
    rdyS = 1'b0;
    setIn(1'b1, 32'd1);
    tick();
    tick();
    setIn(1'b0, 32'd0);
    repeat (70000) tick();
    chk("sat_stall", {16'd0, sStall}, 32'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_after_flush", {16'd0, sStall}, 32'hFFFF);
    chk("sat_flush_valid", {31'd0, sOutValid}, 32'd0);
    rstS = 1'b0;
    tick();
    chk("sat_reset_clear", {16'd0, sStall}, 32'd0);
    chk("sat_reset_ready", {31'd0, sInReady}, 32'd0);

    // single-register mode
    rstF = 1'b1;
    rdyF = 1'b0;
    setIn(1'b1, 32'h50);
    #1;
    chk("flat_ready_empty", {31'd0, fInReady}, 32'd1);
    tick();
    chk("flat_valid", {31'd0, fOutValid}, 32'd1);
    chk("flat_head50", fResult, 32'h50);
    setIn(1'b1, 32'h51);
    #1;
    chk("flat_ready_blocked", {31'd0, fInReady}, 32'd0);
    tick();
    chk("flat_hold50", fResult, 32'h50);
    chk("flat_stall1", {16'd0, fStall}, 32'd1);
    rdyF = 1'b1;
    #1;
    chk("flat_ready_same_cycle", {31'd0, fInReady}, 32'd1);
    tick();
    chk("flat_replaced", fResult, 32'h51);
    chk("flat_valid2", {31'd0, fOutValid}, 32'd1);
    setIn(1'b0, 32'd0);
    tick();
    chk("flat_empty", {31'd0, fOutValid}, 32'd0);
    chk("flat_empty_result", fResult, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the processor datapath, intended for EX/MEM and later stage boundaries. It carries a generic control bus, a result word, store data, destination register and branch redirect across one clock edge. It adds what the fixed-width stage lacked: a valid/ready handshake with back-pressure, a flush that squashes every held entry, an optional 2-entry skid buffer that removes the combinational ready path, and a saturating stall counter.

## Interface
- DATA_W, 32, width of result and store data
- CTRL_W, 9, width of control bus (bit 2 MemRead, 4 MemWrite, 6 RegWrite, 8 Word at default)
- ADDR_W, 5, destination register index width
- PC_W, 32, branch target width
- SKID, 1, 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready
- clock  in  1  sole clock, all state on posedge
- resetn  in  1  synchronous, active-low reset
- flush  in  1  squash all held entries and drop the current input
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bits
- in_result  in  DATA_W  ALU result / address
- in_store_data  in  DATA_W  store data (readData2)
- in_rd  in  ADDR_W  destination register
- in_pc_branch  in  PC_W  branch target
- in_pc_src  in  1  branch taken
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes head
- out_ctrl, out_result, out_store_data, out_rd, out_pc_branch, out_pc_src  out  as inputs  head entry fields
- stall_cycles  out  16  saturating count of back-pressured cycles

## Operation
- Accept: in_valid && in_ready && !flush. Dequeue: out_valid && out_ready.
- All payload outputs read 0 whenever out_valid = 0; out_pc_src is never 1 without out_valid.
- SKID=0: one entry. in_ready = resetn && (!out_valid || out_ready), combinational. Simultaneous accept and dequeue replaces the head.
- SKID=1: head + skid registers; states EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE (into head).
  - ONE: accept only -> TWO (into skid); dequeue only -> EMPTY; both -> ONE, head = new entry.
  - TWO: in_ready = 0; dequeue -> ONE, skid moves to head.
  - in_ready = resetn && state != TWO, taken from a register only.
- Order strictly FIFO; no entry duplicated or lost except by flush.
- flush: next edge -> EMPTY, out_valid = 0, all payload registers cleared; input at that edge dropped even if in_valid && in_ready. flush ignores out_ready.
- stall_cycles: +1 each cycle with out_valid && !out_ready && !flush; holds at 16'hFFFF; cleared only by reset.
- Reset (resetn = 0 at posedge): state EMPTY, out_valid 0, every payload output 0, stall_cycles 0; in_ready reads 0 while resetn low, 1 from the first cycle after release. Reset overrides flush and handshakes; reset mid-transfer discards all entries.

## Timing
- Latency: entry accepted at edge N is on outputs after edge N (visible in cycle N+1), both modes.
- Throughput: 1 entry/cycle while out_ready held high.
- SKID=1: out_ready dropping at cycle N still lets the entry presented in cycle N be accepted (into skid); in_ready falls after that edge.
- Outputs all registered except in_ready for SKID=0.

## Structure
- Shared package: control-bit index constants (CB_MEMREAD=2, CB_MEMWRITE=4, CB_REGWRITE=6, CB_WORD=8), state encoding EMPTY/ONE/TWO, STALL_W=16.
- Payload concatenated into one bus of CTRL_W+2*DATA_W+ADDR_W+PC_W+1 bits internally.
- One sub-module natural: pipe_entry_reg (payload register with load enable and synchronous clear), instantiated for head and skid.

## Test plan
- Reset: hold resetn=0 two cycles with in_valid=1 -> out_valid=0, all payload 0, in_ready=0, stall_cycles=0; release -> in_ready=1.
- Streaming, out_ready=1: ten entries in_result=0..9 back-to-back -> out_result 0..9 on consecutive cycles, one-cycle latency, no gaps.
- Back-pressure, SKID=1: send A,B,C with out_ready=0 from cycle of B -> A at head, B in skid, in_ready=0, C held upstream; stall_cycles increments per cycle; release -> A,B,C in order.
- Flush in TWO with in_valid=1 (entry D) -> next cycle out_valid=0, out_pc_src=0, payload 0, D not delivered; in_ready=1.
- Redirect: in_pc_src=1, in_pc_branch=32'h0000_0040 -> out_pc_src=1 with out_pc_branch=32'h40 only while out_valid=1.
- Saturation and SKID=0: force 70000 stalled cycles -> stall_cycles=16'hFFFF; SKID=0 with out_valid=1, out_ready=1 -> in_ready=1 same cycle and head replaced.
